// File: rtl/rvv_vreg_file_sb.sv
// rvv_vreg_file_sb: multi-write-port vector register file with byte enables and busy scoreboard
// Optional read-during-write forwarding when RVV_VRF_BYPASS_EN is defined.
module rvv_vreg_file_sb #(
  parameter int VLEN     = 512,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 2,
  parameter int NUM_RD   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*5-1:0]      rd_addr,
  output logic [NUM_RD*VLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_valid,
  input  logic [4:0]               rsv_addr,
  output logic                     rsv_ready,
  input  logic [NUM_WR-1:0]        wr_valid,
  input  logic [NUM_WR*5-1:0]      wr_addr,
  input  logic [NUM_WR*VLEN-1:0]   wr_data,
  input  logic [NUM_WR*VLEN/8-1:0] wr_be,
  input  logic [NUM_WR-1:0]        wr_last,
  output logic [VLEN-1:0]          v0_mask,
  output logic                     wr_conflict,
  output logic [NUM_REGS-1:0]      busy_vec
);
  localparam int NB = VLEN / 8;
  logic [VLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy, clr, busy_eff, set;
  logic                conflict;
  always_comb begin
    clr = '0;
    conflict = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_valid[p] && wr_last[p]) clr[wr_addr[p*5 +: 5]] = 1'b1;
      for (int q = p + 1; q < NUM_WR; q++)
        if (wr_valid[p] && wr_valid[q] && wr_addr[p*5 +: 5] == wr_addr[q*5 +: 5]) conflict = 1'b1;
    end
  end
`ifdef RVV_VRF_BYPASS_EN
  assign busy_eff = busy & ~clr;
`else
  assign busy_eff = busy;
`endif
  assign rsv_ready = !busy_eff[rsv_addr];
  always_comb begin
    set = '0;
    set[rsv_addr] = rsv_valid && rsv_ready;
  end
  assign busy_vec = busy;
  // later ports overwrite earlier ones per byte, so the highest index wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy        <= '0;
      v0_mask     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        for (int b = 0; b < NB; b++)
          if (wr_valid[p] && wr_be[p*NB + b])
            regs[wr_addr[p*5 +: 5]][b*8 +: 8] <= wr_data[p*VLEN + b*8 +: 8];
      busy        <= (busy & ~clr) | set;
      v0_mask     <= regs[0];
      wr_conflict <= conflict;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [VLEN-1:0] d;
    always_comb begin
      d = regs[rd_addr[i*5 +: 5]];
`ifdef RVV_VRF_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++)
        for (int b = 0; b < NB; b++)
          if (wr_valid[p] && wr_be[p*NB + b] && wr_addr[p*5 +: 5] == rd_addr[i*5 +: 5])
            d[b*8 +: 8] = wr_data[p*VLEN + b*8 +: 8];
`endif
    end
    assign rd_data[i*VLEN +: VLEN] = d;
    assign rd_busy[i] = busy_eff[rd_addr[i*5 +: 5]];
  end
endmodule
